// File: rtl/uart_fifo_ctrl_pkg.sv
// Shared types and sizing helpers for the buffered UART front end.
`ifndef GET_WIDTH
`define GET_WIDTH(x) $clog2(x)
`endif

package uart_fifo_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_GAP  = 2'd2
   } tx_state_e;

   // One extra MSB lets full and empty be told apart with equal low bits.
   function automatic int ptr_width(input int depth);
      return `GET_WIDTH(depth) + 1;
   endfunction

   function automatic int cnt_width(input int n);
      return (n < 2) ? 1 : `GET_WIDTH(n);
   endfunction

endpackage

// File: rtl/uart_fifo_ctrl_if.sv
// Host push/pop port and uart engine handshake of the FIFO front end.
interface uart_fifo_ctrl_if;
   logic [7:0] tx_data;
   logic       tx_push;
   logic       tx_full;
   logic       tx_empty;
   logic [7:0] rx_data;
   logic       rx_pop;
   logic       rx_empty;
   logic       rx_overflow;
   logic       rx_ovf_clr;
   logic       irq;
   logic [7:0] u_data_in;
   logic       u_data_send;
   logic       u_data_sent;
   logic [7:0] u_data_out;
   logic       u_data_received;

   modport slave (
      input  tx_data, tx_push, rx_pop, rx_ovf_clr,
      input  u_data_sent, u_data_out, u_data_received,
      output tx_full, tx_empty, rx_data, rx_empty, rx_overflow, irq,
      output u_data_in, u_data_send
   );

   modport master (
      output tx_data, tx_push, rx_pop, rx_ovf_clr,
      output u_data_sent, u_data_out, u_data_received,
      input  tx_full, tx_empty, rx_data, rx_empty, rx_overflow, irq,
      input  u_data_in, u_data_send
   );
endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock first-word fall-through FIFO; a push into a full FIFO is
// accepted only when a pop frees a slot in the same cycle.
module uart_sync_fifo
   import uart_fifo_ctrl_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] din_i,
   input  logic             pop_i,
   output logic             full_o,
   output logic             empty_o,
   output logic [WIDTH-1:0] head_o
);
   localparam int PW = ptr_width(DEPTH);
   localparam int AW = PW - 1;

   logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push, do_pop;

   assign empty_o = (wr_q == rd_q);
   assign full_o  = (wr_q[PW-1] != rd_q[PW-1]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);
   assign wr_d    = do_push ? wr_q + PW'(1) : wr_q;
   assign rd_d    = do_pop  ? rd_q + PW'(1) : rd_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
   end

   // Storage is not reset, so the head reads as zero whenever nothing is held.
   assign head_o = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

endmodule

// File: rtl/uart_fifo_ctrl.sv
// Buffered host front end for the uart engine: TX FIFO with paced sender,
// RX FIFO with sticky overflow. Define UART_FIFO_IRQ_EN to build the irq logic.
//
// state   | meaning
// --------+---------------------------------------------------------
// ST_IDLE | nothing in flight; next byte (FIFO head or bypass) launched
// ST_BUSY | byte handed to the engine, waiting for u_data_sent
// ST_GAP  | line settling after a stop bit before the next launch
module uart_fifo_ctrl
   import uart_fifo_ctrl_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int TX_GAP = 8
) (
   input logic             clk,
   input logic             rst_n,
   uart_fifo_ctrl_if.slave bus
);
   localparam int GW = cnt_width(TX_GAP);

   tx_state_e   state_q;
   logic [7:0]  din_q;
   logic        send_q;
   logic [GW-1:0] gap_q;

   logic        txf_full, txf_empty, txf_push, txf_pop, bypass, tx_fire, tx_empty_w;
   logic [7:0]  txf_head;
   logic        rxf_full, rxf_empty;
   logic [7:0]  rxf_head;
   logic        ovf_q, ovf_d;

   // An idle sender with an empty FIFO takes the pushed byte directly.
   assign bypass     = (state_q == ST_IDLE) & txf_empty & bus.tx_push;
   assign txf_pop    = (state_q == ST_IDLE) & ~txf_empty;
   assign txf_push   = bus.tx_push & ~txf_full & ~bypass;
   assign tx_fire    = txf_pop | bypass;
   assign tx_empty_w = txf_empty & (state_q == ST_IDLE);

   uart_sync_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_tx_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (txf_push),
      .din_i   (bus.tx_data),
      .pop_i   (txf_pop),
      .full_o  (txf_full),
      .empty_o (txf_empty),
      .head_o  (txf_head)
   );

   uart_sync_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_rx_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (bus.u_data_received),
      .din_i   (bus.u_data_out),
      .pop_i   (bus.rx_pop),
      .full_o  (rxf_full),
      .empty_o (rxf_empty),
      .head_o  (rxf_head)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         din_q   <= '0;
         send_q  <= 1'b0;
         gap_q   <= '0;
      end else begin
         send_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (tx_fire) begin
                  din_q   <= txf_pop ? txf_head : bus.tx_data;
                  send_q  <= 1'b1;
                  state_q <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (bus.u_data_sent) begin
                  gap_q   <= GW'(TX_GAP - 1);
                  state_q <= ST_GAP;
               end
            end
            ST_GAP: begin
               if (gap_q == '0) state_q <= ST_IDLE;
               else             gap_q   <= gap_q - GW'(1);
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // A fresh drop outranks a clear arriving in the same cycle.
   assign ovf_d = (bus.u_data_received & rxf_full & ~bus.rx_pop) | (ovf_q & ~bus.rx_ovf_clr);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ovf_q <= 1'b0;
      else        ovf_q <= ovf_d;
   end

`ifdef UART_FIFO_IRQ_EN
   logic busy_q, irq_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= 1'b0;
         irq_q  <= 1'b0;
      end else begin
         busy_q <= tx_fire ? 1'b1 : (bus.tx_push ? 1'b0 : busy_q);
         irq_q  <= ~rxf_empty | ovf_q | (tx_empty_w & busy_q);
      end
   end

   assign bus.irq = irq_q;
`else
   assign bus.irq = 1'b0;
`endif

   assign bus.tx_full     = txf_full;
   assign bus.tx_empty    = tx_empty_w;
   assign bus.rx_data     = rxf_head;
   assign bus.rx_empty    = rxf_empty;
   assign bus.rx_overflow = ovf_q;
   assign bus.u_data_in   = din_q;
   assign bus.u_data_send = send_q;

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Randomized bench for uart_fifo_ctrl against a queue-based reference model.
module tb_uart_fifo_ctrl;
   localparam int DEPTH  = 16;
   localparam int TX_GAP = 8;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   uart_fifo_ctrl_if bus();

   uart_fifo_ctrl #(.DEPTH(DEPTH), .TX_GAP(TX_GAP)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_chk = 0;
   int n_pass = 0;

   logic [7:0] txq[$];
   logic [7:0] rxq[$];
   bit         m_inflight, m_send, m_ovf, m_busy, m_irq;
   logic [7:0] m_din;
   int         m_cyc, m_idle_at;

   int         sent_delay, sent_cd;
   int         send_cyc[$];
   logic [7:0] send_dat[$];
   int         sent_cyc[$];
   logic [7:0] last_rx;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
   endtask

   function automatic bit m_tx_empty();
      return (txq.size() == 0) && !m_inflight && (m_cyc >= m_idle_at);
   endfunction

   task automatic model_reset();
      txq.delete();
      rxq.delete();
      m_inflight = 0; m_send = 0; m_ovf = 0; m_busy = 0; m_irq = 0;
      m_din = 8'h00; m_cyc = 0; m_idle_at = 0;
      sent_cd = 0;
   endtask

   // Expected state for the cycle about to end, from the inputs applied in it.
   task automatic model_update();
      bit ready, txe, rxe, ovf_now, nsend, rx_full0, drop;
      int sz0;
      ready    = !m_inflight && (m_cyc >= m_idle_at);
      txe      = m_tx_empty();
      rxe      = (rxq.size() == 0);
      ovf_now  = m_ovf;
      sz0      = txq.size();
      nsend    = 0;
      drop     = 0;
      if (ready) begin
         if (sz0 > 0) begin
            m_din = txq.pop_front();
            nsend = 1;
         end else if (bus.tx_push) begin
            m_din = bus.tx_data;
            nsend = 1;
         end
      end
      if (bus.tx_push && sz0 < DEPTH && !(ready && sz0 == 0)) txq.push_back(bus.tx_data);
      if (nsend) m_inflight = 1;
      else if (m_inflight && bus.u_data_sent) begin
         m_inflight = 0;
         m_idle_at  = m_cyc + TX_GAP + 1;
      end
      rx_full0 = (rxq.size() == DEPTH);
      if (bus.rx_pop && rxq.size() > 0) void'(rxq.pop_front());
      if (bus.u_data_received) begin
         if (!rx_full0 || bus.rx_pop) rxq.push_back(bus.u_data_out);
         else drop = 1;
      end
      if (bus.rx_ovf_clr) m_ovf = 0;
      if (drop) m_ovf = 1;
`ifdef UART_FIFO_IRQ_EN
      m_irq  = !rxe || ovf_now || (txe && m_busy);
      m_busy = nsend ? 1'b1 : (bus.tx_push ? 1'b0 : m_busy);
`else
      m_irq  = 0;
`endif
      m_send = nsend;
      m_cyc++;
   endtask

   task automatic check_all();
      chk("tx_full",  32'(bus.tx_full),     32'(txq.size() == DEPTH));
      chk("tx_empty", 32'(bus.tx_empty),    32'(m_tx_empty()));
      chk("u_send",   32'(bus.u_data_send), 32'(m_send));
      chk("u_din",    32'(bus.u_data_in),   32'(m_din));
      chk("rx_empty", 32'(bus.rx_empty),    32'(rxq.size() == 0));
      if (rxq.size() != 0) chk("rx_data", 32'(bus.rx_data), 32'(rxq[0]));
      chk("rx_ovf",   32'(bus.rx_overflow), 32'(m_ovf));
      chk("irq",      32'(bus.irq),         32'(m_irq));
      if (bus.u_data_send) begin
         send_cyc.push_back(m_cyc);
         send_dat.push_back(bus.u_data_in);
      end
      if (!bus.rx_empty) last_rx = bus.rx_data;
   endtask

   task automatic step(input bit push, input logic [7:0] d, input bit pop,
                       input bit rcv, input logic [7:0] rd, input bit clr);
      @(negedge clk);
      check_all();
      bus.tx_push         = push;
      bus.tx_data         = d;
      bus.rx_pop          = pop;
      bus.u_data_received = rcv;
      bus.u_data_out      = rd;
      bus.rx_ovf_clr      = clr;
      bus.u_data_sent     = (sent_cd == 1);
      if (sent_cd > 0) sent_cd--;
      if (bus.u_data_sent) sent_cyc.push_back(m_cyc);
      if (m_send && sent_delay > 0) sent_cd = sent_delay;
      @(posedge clk);
      model_update();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 8'h00, 0, 0, 8'h00, 0);
   endtask

   task automatic zero_inputs();
      bus.tx_push = 0; bus.tx_data = 8'h00; bus.rx_pop = 0; bus.rx_ovf_clr = 0;
      bus.u_data_sent = 0; bus.u_data_out = 8'h00; bus.u_data_received = 0;
   endtask

   task automatic chk_reset(input string p);
      chk({p, "_tx_full"},  32'(bus.tx_full),     32'(0));
      chk({p, "_tx_empty"}, 32'(bus.tx_empty),    32'(1));
      chk({p, "_rx_empty"}, 32'(bus.rx_empty),    32'(1));
      chk({p, "_rx_data"},  32'(bus.rx_data),     32'(0));
      chk({p, "_rx_ovf"},   32'(bus.rx_overflow), 32'(0));
      chk({p, "_irq"},      32'(bus.irq),         32'(0));
      chk({p, "_u_din"},    32'(bus.u_data_in),   32'(0));
      chk({p, "_u_send"},   32'(bus.u_data_send), 32'(0));
   endtask

   initial begin
      rst_n = 1'b0;
      zero_inputs();
      sent_delay = 0;
      last_rx = 8'h00;
      model_reset();
      #3;
      chk_reset("por");
      @(posedge clk); @(posedge clk);
      #2 rst_n = 1'b1;

      // Two bytes through a slow engine; second launch must respect the gap.
      sent_delay = 200;
      step(1, 8'h55, 0, 0, 8'h00, 0);
      step(1, 8'hA3, 0, 0, 8'h00, 0);
      idle(440);
      #1;
      chk("t1_nsend", 32'(send_cyc.size()), 32'(2));
      if (send_cyc.size() == 2 && sent_cyc.size() >= 1) begin
         chk("t1_byte0", 32'(send_dat[0]), 32'h55);
         chk("t1_byte1", 32'(send_dat[1]), 32'hA3);
         chk("t1_gap_ok", 32'(send_cyc[1] - sent_cyc[0] >= TX_GAP + 1), 32'(1));
      end
      chk("t1_tx_empty", 32'(bus.tx_empty), 32'(1));

      // Stalled engine: one byte in flight, sixteen queued.
      send_cyc.delete(); send_dat.delete(); sent_cyc.delete();
      sent_delay = 0;
      for (int i = 0; i < 17; i++) step(1, 8'($urandom), 0, 0, 8'h00, 0);
      #1;
      chk("t2_tx_full", 32'(bus.tx_full), 32'(1));
      chk("t2_nsend", 32'(send_cyc.size()), 32'(1));

      // Asynchronous reset while a byte is in flight.
      #1 rst_n = 1'b0;
      #1 chk_reset("async");
      zero_inputs();
      model_reset();
      send_cyc.delete(); send_dat.delete(); sent_cyc.delete();
      @(posedge clk); @(posedge clk);
      #2 rst_n = 1'b1;
      idle(20);
      #1 chk("t2_no_send_after_rst", 32'(send_cyc.size()), 32'(0));

      // RX overflow: seventeen strobes, no pops.
      for (int i = 0; i < 17; i++) step(0, 8'h00, 0, 1, 8'(i), 0);
      #1;
      chk("t3_ovf_set", 32'(bus.rx_overflow), 32'(1));
      chk("t3_head", 32'(bus.rx_data), 32'h00);
      for (int i = 0; i < 16; i++) step(0, 8'h00, 1, 0, 8'h00, 0);
      #1 chk("t3_drained", 32'(bus.rx_empty), 32'(1));
      chk("t3_last", 32'(last_rx), 32'h0F);
      step(0, 8'h00, 0, 0, 8'h00, 1);
      #1 chk("t3_ovf_clr", 32'(bus.rx_overflow), 32'(0));

      // RX full with a receive and a pop in the same cycle.
      for (int i = 0; i < DEPTH; i++) step(0, 8'h00, 0, 1, 8'($urandom), 0);
      step(0, 8'h00, 1, 1, 8'h7E, 0);
      #1 chk("t4_no_ovf", 32'(bus.rx_overflow), 32'(0));
      for (int i = 0; i < DEPTH; i++) step(0, 8'h00, 1, 0, 8'h00, 0);
      #1 chk("t4_last_7e", 32'(last_rx), 32'h7E);

      // Random traffic: light then heavy.
      for (int i = 0; i < 1000; i++) begin
         sent_delay = int'($urandom_range(1, 40));
         step($urandom_range(0, 9) < 3, 8'($urandom), $urandom_range(0, 9) < 4,
              $urandom_range(0, 9) < 3, 8'($urandom), $urandom_range(0, 19) == 0);
      end
      for (int i = 0; i < 1000; i++) begin
         sent_delay = int'($urandom_range(1, 12));
         step($urandom_range(0, 9) < 8, 8'($urandom), $urandom_range(0, 9) < 2,
              $urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 29) == 0);
      end
      idle(50);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
